// File: rtl/shift_register_rx_frame.sv
// UART RX deserialiser: start hunt, LSB-first data, optional parity, 1/2 stop bits, one-entry output hold.
// Latency: o_data_valid rises in the clock cycle after the final stop-bit sample tick.
// Backpressure: none upstream; an uncollected frame is overwritten by the next one and o_overrun is set.
module shift_register_rx_frame #(
  parameter int DATA_BITS  = 7,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_serial_in,
  input  logic                 i_baud_tick_rx,
  input  logic                 i_en,
  input  logic                 i_data_ready,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int                 CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic               LAST_STOP = (STOP_BITS == 2);
  localparam logic               PAR_ON    = (PARITY_EN != 0);
  localparam logic               PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_stop_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bad;
  logic                   r_stop_bad;
  logic [DATA_BITS-1:0]   r_data_out;
  logic                   r_data_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   r_busy;

  logic                   w_stop_bad_nxt;
  logic                   w_par_bad_nxt;
  logic                   w_last_stop;

  // Error terms that include the bit being sampled on this tick.
  assign w_stop_bad_nxt = r_stop_bad | ~i_serial_in;
  assign w_par_bad_nxt  = (^{r_shift, i_serial_in}) != PAR_ODD;
  assign w_last_stop    = (r_stop_cnt == LAST_STOP);

  // Receive FSM, holding register and handshake; everything advances only on enabled baud ticks
  // except the consumer handshake and the enable-driven clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_stop_bad   <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Consumer handshake; a commit on the same edge overrides this below.
      if (r_data_valid && i_data_ready) begin
        r_data_valid <= 1'b0;
      end

      if (!i_en) begin
        // Disabled: drop any partial frame, keep the last committed frame readable.
        r_state    <= ST_IDLE;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_shift    <= '0;
        r_par_bad  <= 1'b0;
        r_stop_bad <= 1'b0;
        r_overrun  <= 1'b0;
        r_busy     <= 1'b0;
      end else if (i_baud_tick_rx) begin
        case (r_state)
          ST_IDLE: begin
            // A low line at a tick is a start bit, even straight after a stop bit.
            if (!i_serial_in) begin
              r_state    <= ST_DATA;
              r_bit_cnt  <= '0;
              r_stop_cnt <= 1'b0;
              r_par_bad  <= 1'b0;
              r_stop_bad <= 1'b0;
              r_busy     <= 1'b1;
            end
          end

          ST_DATA: begin
            for (int i = 0; i < DATA_BITS; i++) begin
              if (r_bit_cnt == CNT_W'(i)) begin
                r_shift[i] <= i_serial_in;
              end
            end
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= PAR_ON ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end

          ST_PARITY: begin
            r_par_bad  <= w_par_bad_nxt;
            r_stop_cnt <= 1'b0;
            r_state    <= ST_STOP;
          end

          ST_STOP: begin
            r_stop_bad <= w_stop_bad_nxt;
            if (w_last_stop) begin
              // Commit even on a bad stop bit; the flag travels with the data.
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_data_out   <= r_shift;
              r_parity_err <= PAR_ON & r_par_bad;
              r_frame_err  <= w_stop_bad_nxt;
              r_data_valid <= 1'b1;
              if (r_data_valid && !i_data_ready) begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_shift_register_rx_frame.sv
// Bench for shift_register_rx_frame: three parameterisations driven with directed frames.
// A frame-level model predicts the output register contents; a compare process checks every cycle.
// Literal checks pin the expected values of the directed scenarios.
module tb_shift_register_rx_frame;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: 7N1, instance 1: 8E1, instance 2: 5O2
  int cfg_db[3] = '{7, 8, 5};
  int cfg_pe[3] = '{0, 1, 1};
  int cfg_po[3] = '{0, 0, 1};
  int cfg_sb[3] = '{1, 1, 2};

  logic ser[3]   = '{1'b1, 1'b1, 1'b1};
  logic tick[3]  = '{1'b0, 1'b0, 1'b0};
  logic en_i[3]  = '{1'b1, 1'b1, 1'b1};
  logic rdy[3]   = '{1'b0, 1'b0, 1'b0};

  logic [6:0] dout0;
  logic [7:0] dout1;
  logic [4:0] dout2;
  logic [8:0] a_data[3];
  logic a_valid[3], a_perr[3], a_ferr[3], a_ovr[3], a_busy[3];

  assign a_data[0] = {2'b00, dout0};
  assign a_data[1] = {1'b0, dout1};
  assign a_data[2] = {4'b0000, dout2};

  shift_register_rx_frame #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_serial_in(ser[0]), .i_baud_tick_rx(tick[0]),
    .i_en(en_i[0]), .i_data_ready(rdy[0]), .o_data_out(dout0), .o_data_valid(a_valid[0]),
    .o_parity_err(a_perr[0]), .o_frame_err(a_ferr[0]), .o_overrun(a_ovr[0]), .o_busy(a_busy[0]));

  shift_register_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_serial_in(ser[1]), .i_baud_tick_rx(tick[1]),
    .i_en(en_i[1]), .i_data_ready(rdy[1]), .o_data_out(dout1), .o_data_valid(a_valid[1]),
    .o_parity_err(a_perr[1]), .o_frame_err(a_ferr[1]), .o_overrun(a_ovr[1]), .o_busy(a_busy[1]));

  shift_register_rx_frame #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_serial_in(ser[2]), .i_baud_tick_rx(tick[2]),
    .i_en(en_i[2]), .i_data_ready(rdy[2]), .o_data_out(dout2), .o_data_valid(a_valid[2]),
    .o_parity_err(a_perr[2]), .o_frame_err(a_ferr[2]), .o_overrun(a_ovr[2]), .o_busy(a_busy[2]));

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: expected contents of the output register per instance.
  bit       m_valid[3], m_perr[3], m_ferr[3], m_ovr[3], m_busy[3];
  bit [8:0] m_data[3];
  // Stimulus annotations: this tick ends a frame / busy after this tick; pending frame result.
  bit       m_commit[3], m_bnext[3];
  bit [8:0] p_data[3];
  bit       p_perr[3], p_ferr[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_valid[k] = 0; m_perr[k] = 0; m_ferr[k] = 0; m_ovr[k] = 0; m_busy[k] = 0; m_data[k] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!en_i[k]) begin
          m_ovr[k]  = 0;
          m_busy[k] = 0;
          if (m_valid[k] && rdy[k]) m_valid[k] = 0;
        end else if (tick[k] && m_commit[k]) begin
          if (m_valid[k] && !rdy[k]) m_ovr[k] = 1;
          m_valid[k] = 1;
          m_data[k]  = p_data[k];
          m_perr[k]  = p_perr[k];
          m_ferr[k]  = p_ferr[k];
          m_busy[k]  = 0;
        end else begin
          if (m_valid[k] && rdy[k]) m_valid[k] = 0;
          if (tick[k]) m_busy[k] = m_bnext[k];
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d data_out", k),   32'(a_data[k]),  32'(m_data[k]));
      chk($sformatf("u%0d data_valid", k), 32'(a_valid[k]), 32'(m_valid[k]));
      chk($sformatf("u%0d parity_err", k), 32'(a_perr[k]),  32'(m_perr[k]));
      chk($sformatf("u%0d frame_err", k),  32'(a_ferr[k]),  32'(m_ferr[k]));
      chk($sformatf("u%0d overrun", k),    32'(a_ovr[k]),   32'(m_ovr[k]));
      chk($sformatf("u%0d busy", k),       32'(a_busy[k]),  32'(m_busy[k]));
    end
  end

  // One clock of stimulus for instance k; called and returns just after a falling edge.
  task automatic step(input int k, input logic s, input logic t, input logic e, input logic r,
                      input bit c, input bit bn);
    ser[k] = s; tick[k] = t; en_i[k] = e; rdy[k] = r;
    m_commit[k] = c; m_bnext[k] = bn;
    @(posedge clk);
    @(negedge clk);
    tick[k] = 1'b0; rdy[k] = 1'b0; en_i[k] = 1'b1; m_commit[k] = 0;
  endtask

  // Send one frame with two garbage cycles before each tick; abort_after>=0 drops en at that tick.
  task automatic send_frame(input int k, input logic [8:0] data, input logic par, input logic [1:0] stops,
                            input logic rdy_gap, input logic rdy_last, input int abort_after);
    logic     q[$];
    bit [8:0] mask;
    int       last;
    mask = 9'((1 << cfg_db[k]) - 1);
    q.push_back(1'b0);
    for (int i = 0; i < cfg_db[k]; i++) q.push_back(data[i]);
    if (cfg_pe[k] != 0) q.push_back(par);
    for (int i = 0; i < cfg_sb[k]; i++) q.push_back(stops[i]);
    p_data[k] = data & mask;
    p_perr[k] = (cfg_pe[k] != 0) && ((($countones(data & mask) + int'(par)) % 2) != cfg_po[k]);
    p_ferr[k] = (stops[0] == 1'b0) || (cfg_sb[k] == 2 && stops[1] == 1'b0);
    last = q.size() - 1;
    for (int j = 0; j <= last; j++) begin
      if (abort_after >= 0 && j == abort_after) begin
        step(k, 1'b0, 1'b1, 1'b0, rdy_gap, 0, 0);
        return;
      end
      step(k, ~q[j], 1'b0, 1'b1, rdy_gap, 0, 0);
      step(k, ~q[j], 1'b0, 1'b1, rdy_gap, 0, 0);
      step(k, q[j], 1'b1, 1'b1, (j == last) ? rdy_last : rdy_gap, j == last, j != last);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset data_out", 32'(dout0), 32'h0);
    chk("reset valid", 32'(a_valid[0]), 32'h0);
    chk("reset busy", 32'(a_busy[0]), 32'h0);
    chk("reset overrun", 32'(a_ovr[2]), 32'h0);
    rst_n = 1'b1;
    step(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

    // T1: 7N1, samples 0,1,0,1,1,0,0,1,1
    send_frame(0, 9'h04D, 1'b0, 2'b11, 1'b0, 1'b0, -1);
    chk("t1 data", 32'(dout0), 32'h4D);
    chk("t1 valid", 32'(a_valid[0]), 32'h1);
    chk("t1 errs", 32'({a_perr[0], a_ferr[0]}), 32'h0);
    chk("t1 busy", 32'(a_busy[0]), 32'h0);
    step(0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    chk("t1 consumed", 32'(a_valid[0]), 32'h0);

    // T2: 8E1, good parity then bad parity
    send_frame(1, 9'h0A5, 1'b0, 2'b11, 1'b0, 1'b0, -1);
    chk("t2 data", 32'(dout1), 32'hA5);
    chk("t2 par ok", 32'(a_perr[1]), 32'h0);
    send_frame(1, 9'h0A5, 1'b1, 2'b11, 1'b1, 1'b0, -1);
    chk("t2 data bad par", 32'(dout1), 32'hA5);
    chk("t2 par bad", 32'(a_perr[1]), 32'h1);
    chk("t2 no overrun", 32'(a_ovr[1]), 32'h0);

    // 5O2: second stop bit low, then bad odd parity with good stops
    send_frame(2, 9'h013, 1'b0, 2'b01, 1'b0, 1'b0, -1);
    chk("5o2 data", 32'(dout2), 32'h13);
    chk("5o2 stop2 bad", 32'({a_perr[2], a_ferr[2]}), 32'h1);
    send_frame(2, 9'h013, 1'b1, 2'b11, 1'b1, 1'b0, -1);
    chk("5o2 par bad", 32'({a_perr[2], a_ferr[2]}), 32'h2);

    // T3: stop sampled low, then a clean frame
    send_frame(0, 9'h04D, 1'b0, 2'b00, 1'b0, 1'b0, -1);
    chk("t3 data", 32'(dout0), 32'h4D);
    chk("t3 frame_err", 32'(a_ferr[0]), 32'h1);
    send_frame(0, 9'h012, 1'b0, 2'b11, 1'b1, 1'b0, -1);
    chk("t3 data2", 32'(dout0), 32'h12);
    chk("t3 frame_err clr", 32'(a_ferr[0]), 32'h0);

    // T4: two uncollected frames -> overrun, consume, then disable clears overrun
    step(0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0, 1'b0, -1);
    send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0, 1'b0, -1);
    chk("t4 data", 32'(dout0), 32'h22);
    chk("t4 overrun", 32'(a_ovr[0]), 32'h1);
    step(0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    chk("t4 consumed", 32'(a_valid[0]), 32'h0);
    chk("t4 overrun sticky", 32'(a_ovr[0]), 32'h1);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("t4 overrun clr", 32'(a_ovr[0]), 32'h0);
    chk("t4 data held", 32'(dout0), 32'h22);

    // T5: abort after 3 data bits (tick with en=0 and a low line must be ignored)
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b0, 1'b0, 4);
    chk("t5 busy after abort", 32'(a_busy[0]), 32'h0);
    chk("t5 no commit", 32'(a_valid[0]), 32'h0);
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b0, 1'b0, -1);
    chk("t5 data", 32'(dout0), 32'h3C);
    chk("t5 valid", 32'(a_valid[0]), 32'h1);
    step(0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("t5 only once", 32'(a_valid[0]), 32'h0);

    // T6: asynchronous reset mid-DATA and mid-cycle
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1);
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1);
    chk("t6 busy mid frame", 32'(a_busy[0]), 32'h1);
    ser[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async busy", 32'(a_busy[0]), 32'h0);
    chk("t6 async data0", 32'(dout0), 32'h0);
    chk("t6 async data1", 32'(dout1), 32'h0);
    chk("t6 async perr1", 32'(a_perr[1]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

    // Back-to-back frames, ready only on the second commit cycle
    send_frame(0, 9'h015, 1'b0, 2'b11, 1'b0, 1'b0, -1);
    send_frame(0, 9'h02A, 1'b0, 2'b11, 1'b0, 1'b1, -1);
    chk("t6 b2b data", 32'(dout0), 32'h2A);
    chk("t6 b2b valid", 32'(a_valid[0]), 32'h1);
    chk("t6 b2b overrun", 32'(a_ovr[0]), 32'h0);

    repeat (2) step(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
